// File: rtl/pipelined_barrel_shifter.sv
// Pipelined multi-mode barrel shifter (LSL, LSR, ASR, ROL). One log-shifter stage per shift bit.
// Define BSH_FLAGS_EN to add the Z (zero) and C (last bit shifted out) result flags.
module pipelined_barrel_shifter #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] I,
  input  logic [SHW-1:0]   S,
  input  logic [1:0]       MODE,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] O
`ifdef BSH_FLAGS_EN
  ,
  output logic             Z,
  output logic             C
`endif
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high.
  // The whole pipeline moves together; it holds only when a result sits at the output
  // and the sink is not taking it, so in_ready is that same advance condition.

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  logic advance;

  function automatic logic [WIDTH-1:0] shift_data(input logic [WIDTH-1:0] d, input int n,
                                                   input logic [1:0] m);
    logic signed [WIDTH-1:0] sd;
    logic [WIDTH-1:0]        r;
    sd = d;
    r  = d;
    case (m)
      MODE_LSL: r = d << n;
      MODE_LSR: r = d >> n;
      MODE_ASR: r = sd >>> n;
      MODE_ROL: r = (d << n) | (d >> (WIDTH - n));
      default:  r = d;
    endcase
    return r;
  endfunction

`ifdef BSH_FLAGS_EN
  // Left shifts and rotates lose bit WIDTH-n; right shifts lose bit n-1.
  function automatic logic shift_carry(input logic [WIDTH-1:0] d, input int n,
                                       input logic [1:0] m);
    logic [WIDTH-1:0] t;
    if (m == MODE_LSR || m == MODE_ASR) t = d >> (n - 1);
    else                                t = d >> (WIDTH - n);
    return t[0];
  endfunction
`endif

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int N = 2 ** k;

    logic [WIDTH-1:0] src_data;
    logic [SHW-k-1:0] src_s;
    logic [1:0]       src_mode;
    logic             src_valid;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
`ifdef BSH_FLAGS_EN
    logic             src_carry;
    logic             carry_q, carry_d;
`endif

    if (k == 0) begin : g_src
      assign src_data  = I;
      assign src_s     = S;
      assign src_mode  = MODE;
      assign src_valid = in_valid;
`ifdef BSH_FLAGS_EN
      assign src_carry = 1'b0;
`endif
    end else begin : g_src
      assign src_data  = g_stage[k-1].data_q;
      assign src_s     = g_stage[k-1].g_keep.s_q;
      assign src_mode  = g_stage[k-1].g_keep.mode_q;
      assign src_valid = g_stage[k-1].valid_q;
`ifdef BSH_FLAGS_EN
      assign src_carry = g_stage[k-1].carry_q;
`endif
    end

    always_comb begin
      data_d  = src_data;
      valid_d = src_valid;
      if (src_s[0]) data_d = shift_data(src_data, N, src_mode);
    end

`ifdef BSH_FLAGS_EN
    // A pass-through stage keeps the carry produced by the last stage that shifted.
    always_comb begin
      carry_d = src_carry;
      if (src_s[0]) carry_d = shift_carry(src_data, N, src_mode);
    end

    always_ff @(posedge clk) begin
      if (rst)          carry_q <= 1'b0;
      else if (advance) carry_q <= carry_d;
    end
`endif

    always_ff @(posedge clk) begin
      if (rst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else if (advance) begin
        data_q  <= data_d;
        valid_q <= valid_d;
      end
    end

    // Later stages still need the unconsumed shift bits and the mode.
    if (k < SHW - 1) begin : g_keep
      logic [SHW-k-2:0] s_q, s_d;
      logic [1:0]       mode_q, mode_d;

      always_comb begin
        s_d    = src_s[SHW-k-1:1];
        mode_d = src_mode;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          s_q    <= '0;
          mode_q <= 2'b00;
        end else if (advance) begin
          s_q    <= s_d;
          mode_q <= mode_d;
        end
      end
    end
  end

  assign advance   = ~g_stage[SHW-1].valid_q | out_ready;
  assign in_ready  = advance;
  assign out_valid = g_stage[SHW-1].valid_q;
  assign O         = g_stage[SHW-1].data_q;

`ifdef BSH_FLAGS_EN
  logic z_q, z_d;

  always_comb begin
    z_d = (g_stage[SHW-1].data_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst)          z_q <= 1'b0;
    else if (advance) z_q <= z_d;
  end

  assign Z = z_q;
  assign C = g_stage[SHW-1].carry_q;
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (WIDTH=8): directed cases, backpressure,
// mid-flight reset and a randomized stream against an arithmetic reference model.
module tb_pipelined_barrel_shifter;

  localparam int W   = 8;
  localparam int SHW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   din;
  logic [SHW-1:0] sh;
  logic [1:0]     mode;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   dout;
`ifdef BSH_FLAGS_EN
  logic           z_flag;
  logic           c_flag;
`endif

  pipelined_barrel_shifter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .I         (din),
    .S         (sh),
    .MODE      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef BSH_FLAGS_EN
    .Z         (z_flag),
    .C         (c_flag),
`endif
    .O         (dout)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [1:0]   exp_f_q[$];   // {z, c}
  int           exp_lat_q[$]; // accept cycle, or -1 when latency is not checked
  int           n_checks = 0;
  int           n_errors = 0;
  bit           check_lat = 1'b1;
  bit           rand_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model_o(input logic [W-1:0] i, input int s, input logic [1:0] m);
    logic [2*W-1:0] ext;
    logic [W-1:0]   r;
    case (m)
      2'b00:   r = W'(i << s);
      2'b01:   r = i >> s;
      2'b10: begin
        ext = {{W{i[W-1]}}, i} >> s;
        r   = ext[W-1:0];
      end
      default: r = (s == 0) ? i : W'((i << s) | (i >> (W - s)));
    endcase
    return r;
  endfunction

  function automatic logic model_c(input logic [W-1:0] i, input int s, input logic [1:0] m);
    logic [W-1:0] o;
    if (s == 0) return 1'b0;
    o = model_o(i, s, m);
    case (m)
      2'b00:   return i[W-s];
      2'b01:   return i[s-1];
      2'b10:   return i[s-1];
      default: return o[0];
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_op(input logic [W-1:0] i, input logic [SHW-1:0] s, input logic [1:0] m,
                         input logic [W-1:0] eo, input logic ec, input logic ez);
    int t;
    @(posedge clk); #1;
    in_valid = 1'b1;
    din      = i;
    sh       = s;
    mode     = m;
    @(negedge clk);
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    else begin
      exp_q.push_back(eo);
      exp_f_q.push_back({ez, ec});
      exp_lat_q.push_back(check_lat ? cyc : -1);
    end
  endtask

  task automatic send_model(input logic [W-1:0] i, input logic [SHW-1:0] s, input logic [1:0] m);
    logic [W-1:0] eo;
    eo = model_o(i, int'(s), m);
    send_op(i, s, m, eo, model_c(i, int'(s), m), (eo == '0));
  endtask

  // Idle cycles scramble the operand lines to show they matter only when accepted.
  task automatic idle(input int n);
    @(posedge clk); #1;
    in_valid = 1'b0;
    din      = W'($urandom_range(0, 255));
    sh       = SHW'($urandom_range(0, W - 1));
    mode     = 2'($urandom_range(0, 3));
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic drain();
    int t;
    @(posedge clk); #1;
    in_valid = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  always begin
    @(posedge clk); #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- output monitor ----------------
  logic [W-1:0] m_eo;
  logic [1:0]   m_ef;
  int           m_el;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("spurious_out", 32'(out_valid), 32'd0);
      else begin
        m_eo = exp_q.pop_front();
        m_ef = exp_f_q.pop_front();
        m_el = exp_lat_q.pop_front();
        check("out_data", 32'(dout), 32'(m_eo));
`ifdef BSH_FLAGS_EN
        check("flag_z", 32'(z_flag), 32'(m_ef[1]));
        check("flag_c", 32'(c_flag), 32'(m_ef[0]));
`endif
        if (m_el >= 0) check("latency", 32'(cyc - m_el), 32'(SHW));
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    din       = '0;
    sh        = '0;
    mode      = 2'b00;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_o", 32'(dout), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef BSH_FLAGS_EN
    check("rst_z", 32'(z_flag), 32'd0);
    check("rst_c", 32'(c_flag), 32'd0);
`endif

    // Known operand under each mode, then edge operand 0x80 shifted by 7.
    send_op(8'b10110010, 3'd5, 2'b00, 8'b01000000, 1'b0, 1'b0);
    send_op(8'b10110010, 3'd5, 2'b01, 8'b00000101, 1'b1, 1'b0);
    send_op(8'b10110010, 3'd5, 2'b10, 8'b11111101, 1'b1, 1'b0);
    send_op(8'b10110010, 3'd5, 2'b11, 8'b01010110, 1'b0, 1'b0);
    send_op(8'h80, 3'd7, 2'b00, 8'h00, 1'b0, 1'b1);
    send_op(8'h80, 3'd7, 2'b01, 8'h01, 1'b0, 1'b0);
    send_op(8'h80, 3'd7, 2'b10, 8'hFF, 1'b0, 1'b0);
    send_op(8'h80, 3'd7, 2'b11, 8'h40, 1'b0, 1'b0);
    // Zero shift is identity; ROL by 7 is rotate right by 1.
    send_op(8'hA5, 3'd0, 2'b10, 8'hA5, 1'b0, 1'b0);
    send_op(8'h03, 3'd7, 2'b11, 8'h81, 1'b1, 1'b0);
    drain();

    // Back-to-back stream: 0x01 shifted left by 0..7.
    for (int s = 0; s < 8; s++) send_op(8'h01, SHW'(s), 2'b00, W'(1 << s), 1'b0, 1'b0);
    drain();

    // Backpressure with a full pipeline.
    check_lat = 1'b0;
    @(posedge clk); #1 out_ready = 1'b0;
    for (int n = 0; n < 3; n++)
      send_model(W'($urandom_range(0, 255)), SHW'($urandom_range(0, W - 1)), 2'($urandom_range(0, 3)));
    fork
      send_model(W'($urandom_range(0, 255)), SHW'($urandom_range(0, W - 1)), 2'($urandom_range(0, 3)));
      begin
        @(posedge clk);
        repeat (4) begin
          @(negedge clk);
          check("bp_in_ready", 32'(in_ready), 32'd0);
          check("bp_out_valid", 32'(out_valid), 32'd1);
          check("bp_hold_o", 32'(dout), 32'(exp_q[0]));
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();
    check_lat = 1'b1;

    // Reset with two operands in flight.
    send_model(8'h5A, 3'd1, 2'b00);
    send_model(8'hC3, 3'd2, 2'b10);
    @(posedge clk); #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    exp_f_q.delete();
    exp_lat_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_o", 32'(dout), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    idle(6);

    // Randomized traffic with random gaps and random sink stalls.
    check_lat  = 1'b0;
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      send_model(W'($urandom_range(0, 255)), SHW'($urandom_range(0, W - 1)), 2'($urandom_range(0, 3)));
    end
    drain();
    rand_ready = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
